// File: rtl/fft_pkg.sv
// Shared constants, state encoding and address helpers
// for the radix-2 ping-pong FFT sequencer.
package fft_pkg;

  localparam int FFT_M = 5;
  localparam int N     = 1 << FFT_M;
  localparam int NB    = N / 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [31:0] bitrev(
    input logic [31:0] x,
    input int          m
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < m) r[i] = x[m-1-i];
    end
    return r;
  endfunction

  // Rotate left by r inside an m-bit field.
  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int          r,
    input int          m
  );
    logic [31:0] mask;
    mask = (32'd1 << m) - 32'd1;
    return ((x << r) | ((x & mask) >> (m - r))) & mask;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: operand pair and
// twiddle index from level and butterfly counters.
module fft_agu
  import fft_pkg::*;
#(
  parameter int M  = FFT_M,
  parameter int LW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [LW-1:0] lvl_i,
  input  logic [M-2:0]  j_i,
  output logic [M-1:0]  adr_a_o,
  output logic [M-1:0]  adr_b_o,
  output logic [M-2:0]  twiddle_adr_o
);

  logic [M-1:0] even;
  logic [M-1:0] odd;
  logic [M-2:0] low;
  int           sh;

  assign even = {j_i, 1'b0};
  assign odd  = {j_i, 1'b1};
  assign sh   = M - 1 - int'(lvl_i);

  assign adr_a_o = M'(rotl(32'(even), int'(lvl_i), M));
  assign adr_b_o = M'(rotl(32'(odd), int'(lvl_i), M));

  // Keep only the top lvl bits of j.
  assign low = (M-1)'((32'd1 << sh) - 32'd1);
  assign twiddle_adr_o = j_i & ~low;

endmodule

// File: rtl/fft_sequencer.sv
// Load / compute / readout control for the ping-pong
// radix-2 FFT: RAM addressing, write enables, twiddles.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int M = FFT_M
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load,
  input  logic [M-1:0] rd_adr,
  output logic         done,
  output logic         rd_sel,
  output logic         we0,
  output logic [M-1:0] adr0_a,
  output logic [M-1:0] adr0_b,
  output logic         we1,
  output logic [M-1:0] adr1_a,
  output logic [M-1:0] adr1_b,
  output logic [M-2:0] twiddle_adr
);

  localparam int LW = (M > 1) ? $clog2(M) : 1;
  localparam int NH = (1 << M) / 2;
  localparam logic [M-2:0] JMAX = (M-1)'(NH - 1);
  localparam logic [LW-1:0] LMAX = LW'(M - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [M-2:0]  j_q, j_d;

  logic [M-1:0]  adr_a;
  logic [M-1:0]  adr_b;
  logic [M-2:0]  tw;
  logic [M-1:0]  rev;

  fft_agu #(
    .M  (M),
    .LW (LW)
  ) u_agu (
    .lvl_i         (lvl_q),
    .j_i           (j_q),
    .adr_a_o       (adr_a),
    .adr_b_o       (adr_b),
    .twiddle_adr_o (tw)
  );

  assign rev = M'(bitrev(32'(rd_adr), M));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          lvl_d   = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        j_d = j_q + 1'b1;
        if (j_q == JMAX) begin
          if (lvl_q == LMAX) begin
            state_d = DONE;
            lvl_d   = '0;
          end else begin
            lvl_d = lvl_q + 1'b1;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done        = 1'b0;
    rd_sel      = 1'b0;
    we0         = load;
    we1         = 1'b0;
    adr0_a      = rev;
    adr0_b      = rev;
    adr1_a      = rd_adr;
    adr1_b      = rd_adr;
    twiddle_adr = '0;
    unique case (1'b1)
      (state_q == RUN): begin
        // Even levels read RAM0 into RAM1, odd the reverse.
        rd_sel      = lvl_q[0];
        we0         = lvl_q[0];
        we1         = ~lvl_q[0];
        adr0_a      = adr_a;
        adr0_b      = adr_b;
        adr1_a      = adr_a;
        adr1_b      = adr_b;
        twiddle_adr = tw;
      end
      (state_q == DONE): begin
        done   = 1'b1;
        rd_sel = 1'(M % 2);
        we0    = 1'b0;
        adr0_a = rd_adr;
        adr0_b = rd_adr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Randomized bench for fft_sequencer against a
// cycle-indexed behavioural model of the FFT schedule.
module tb_fft_sequencer;

  localparam int M  = 5;
  localparam int N  = 1 << M;
  localparam int NB = N / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         load;
  logic [M-1:0] rd_adr;
  logic         done;
  logic         rd_sel;
  logic         we0;
  logic [M-1:0] adr0_a;
  logic [M-1:0] adr0_b;
  logic         we1;
  logic [M-1:0] adr1_a;
  logic [M-1:0] adr1_b;
  logic [M-2:0] twiddle_adr;

  int nvec = 0;
  int nerr = 0;
  int mode = 0;
  int cyc  = 0;
  bit obs_done;

  always #5 clk = ~clk;

  fft_sequencer #(.M(M)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load        (load),
    .rd_adr      (rd_adr),
    .done        (done),
    .rd_sel      (rd_sel),
    .we0         (we0),
    .adr0_a      (adr0_a),
    .adr0_b      (adr0_b),
    .we1         (we1),
    .adr1_a      (adr1_a),
    .adr1_b      (adr1_b),
    .twiddle_adr (twiddle_adr)
  );

  task automatic check(string tag, int got, int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s mode=%0d cyc=%0d: got %0d expected %0d",
               tag, mode, cyc, got, exp);
    end
  endtask

  function automatic int rev_ref(int x);
    int r = 0;
    for (int i = 0; i < M; i++) r = r * 2 + (x >> i) % 2;
    return r;
  endfunction

  function automatic int rot_ref(int x, int l);
    return ((x << l) | (x >> (M - l))) % N;
  endfunction

  // Compare outputs mid-cycle, then advance the model
  // by the inputs that the coming edge will see.
  task automatic tick();
    int lvl, j, sh, ea, eb;
    @(negedge clk);
    if (mode == 0) begin
      check("done", done, 0);
      check("rd_sel", rd_sel, 0);
      check("we0", we0, load);
      check("we1", we1, 0);
      check("adr0_a", adr0_a, rev_ref(rd_adr));
      check("adr0_b", adr0_b, rev_ref(rd_adr));
      check("adr1_a", adr1_a, rd_adr);
      check("adr1_b", adr1_b, rd_adr);
      check("tw", twiddle_adr, 0);
    end else if (mode == 1) begin
      lvl = cyc / NB;
      j   = cyc % NB;
      sh  = M - 1 - lvl;
      ea  = rot_ref(2 * j, lvl);
      eb  = rot_ref(2 * j + 1, lvl);
      check("done", done, 0);
      check("rd_sel", rd_sel, lvl % 2);
      check("we0", we0, lvl % 2);
      check("we1", we1, 1 - lvl % 2);
      check("adr0_a", adr0_a, ea);
      check("adr0_b", adr0_b, eb);
      check("adr1_a", adr1_a, ea);
      check("adr1_b", adr1_b, eb);
      check("tw", twiddle_adr, (j >> sh) << sh);
    end else begin
      check("done", done, 1);
      check("rd_sel", rd_sel, M % 2);
      check("we0", we0, 0);
      check("we1", we1, 0);
      check("adr0_a", adr0_a, rd_adr);
      check("adr0_b", adr0_b, rd_adr);
      check("adr1_a", adr1_a, rd_adr);
      check("adr1_b", adr1_b, rd_adr);
    end
    obs_done = done;
    if (reset) begin
      mode = 0;
      cyc  = 0;
    end else if (mode == 0) begin
      if (start) begin
        mode = 1;
        cyc  = 0;
      end
    end else if (mode == 1) begin
      cyc++;
      if (cyc == M * NB) mode = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in(int noise);
    load   = 1'($urandom % 2);
    rd_adr = M'($urandom);
    start  = (noise != 0) && ($urandom % noise == 0);
  endtask

  task automatic episode(int noise);
    int lat;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rnd_in(0);
      tick();
    end
    start  = 1'b1;
    load   = 1'b1;
    rd_adr = M'($urandom);
    tick();
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      rnd_in(noise);
      tick();
      if (obs_done) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, M * NB);
    for (int k = 0; k < 5; k++) begin
      rnd_in(2);
      tick();
    end
    reset = 1'b1;
    rnd_in(2);
    tick();
    reset = 1'b0;
  endtask

  task automatic reset_mid_run();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rnd_in(0);
      tick();
    end
    start = 1'b1;
    tick();
    for (int k = 0; k < 38; k++) begin
      rnd_in(4);
      reset = (k == 37);
      tick();
    end
    reset = 1'b0;
    rnd_in(0);
    tick();
    check("rst_idle", int'(obs_done), 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    load   = 1'b0;
    rd_adr = '0;
    repeat (2) @(posedge clk);
    #1;
    mode = 0;
    cyc  = 0;
    tick();
    episode(0);
    episode(3);
    reset_mid_run();
    episode(0);
    episode(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Control/address-generation FSM for the radix-2 ping-pong FFT engine with two dual-port RAMs, one butterfly unit and the twiddle ROM.
- Controls three phases:
  - Load: bit-reversed write of input samples into RAM0.
  - Compute: one butterfly per cycle, M levels, alternating source and destination RAM.
  - Readout: natural-order reads from the result RAM.
- Sits beside the butterfly, RAMs and twiddle ROM inside the FFT top level.

Parameters:
- M, 5, log2 of FFT length; N = 2^M points, N/2 butterflies per level, M levels.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high; returns FSM to IDLE.
- start  in  1  single-cycle pulse; begins compute when in IDLE.
- load  in  1  high = sample rd_adr is being written (IDLE only).
- rd_adr  in  M  sample index, used for load and for readout.
- done  out  1  high from end of compute until reset.
- rd_sel  out  1  butterfly input mux: 0 = RAM0 ports, 1 = RAM1 ports.
- we0  out  1  RAM0 write enable (both ports).
- adr0_a  out  M  RAM0 port-A address.
- adr0_b  out  M  RAM0 port-B address.
- we1  out  1  RAM1 write enable (both ports).
- adr1_a  out  M  RAM1 port-A address.
- adr1_b  out  M  RAM1 port-B address.
- twiddle_adr  out  M-1  twiddle ROM index k, selecting W_N^k.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- RAM model: RAMs read combinationally and write on the rising clk edge.
- Registered state: FSM state, level counter lvl[log2(M)], butterfly counter j[M-1]. All outputs decode combinationally from these plus load/rd_adr.
- States: IDLE, RUN, DONE. Reset puts the FSM in IDLE with lvl=0, j=0.
- IDLE:
  - we0=load, we1=0, rd_sel=0, done=0, twiddle_adr=0.
  - adr0_a=adr0_b=bitrev(rd_adr); adr1_a=adr1_b=rd_adr.
- Transition IDLE->RUN: on start=1. If load and start are high in the same cycle, the load write happens and RUN starts next cycle.
- RUN, one butterfly per cycle:
  - adrA = rotl_M(2j, lvl); adrB = rotl_M(2j+1, lvl).
  - Rotate-left is within M bits.
  - All four RAM addresses are driven: *_a = adrA, *_b = adrB.
  - twiddle_adr = j with its low (M-1-lvl) bits cleared, i.e. the top lvl bits of j are kept.
  - lvl even: rd_sel=0, we0=0, we1=1 (read RAM0, write RAM1).
  - lvl odd: rd_sel=1, we0=1, we1=0 (read RAM1, write RAM0).
  - j increments each cycle. At j=N/2-1: j wraps to 0 and lvl increments.
  - At lvl=M-1 and j=N/2-1: the write happens that cycle, then RUN->DONE.
  - Compute latency: exactly M*N/2 cycles from the first RUN cycle to done=1. With M=5 this is 80 cycles.
  - done rises the cycle after the final write.
- DONE:
  - done=1, we0=we1=0.
  - All RAM addresses = rd_adr, in natural order.
  - rd_sel = M[0], pointing at the result RAM (RAM1 for odd M).
  - Holds until reset.
- Ignored inputs:
  - start is ignored in RUN and DONE.
  - load is ignored in RUN and DONE; no RAM write results.
- Reset mid-RUN: back to IDLE next edge, we0=we1=0, counters cleared. RAM contents are undefined; the host reloads.
- Reset values: done=0, rd_sel=0, we0=0 (load low), we1=0, twiddle_adr=0.

Decomposition:
- Package fft_pkg:
  - Constants N=2^M and NB=N/2.
  - State enum {IDLE, RUN, DONE}.
  - Pure functions bitrev(x, M) and rotl(x, r, M).
- Sub-module fft_agu (combinational):
  - Inputs: lvl, j.
  - Outputs: adrA, adrB, twiddle_adr.
  - Instantiated once in fft_sequencer; unit-testable standalone.

Test Plan:
- Load, M=3: load=1, rd_adr=1 in IDLE -> we0=1, adr0_a=adr0_b=4, we1=0; rd_adr=3 -> adr0_a=6.
- Address sweep, M=3, start pulse:
  - Cycle 3 (lvl0, j=3) -> adr_a=6, adr_b=7, tw=0, we1=1, rd_sel=0.
  - Cycle 5 (lvl1, j=1) -> adr_a=4, adr_b=6, tw=0, we0=1, rd_sel=1.
  - Cycle 9 (lvl2, j=1) -> adr_a=1, adr_b=5, tw=1, we1=1.
  - done=1 exactly 12 cycles after the first RUN cycle.
- End-to-end, M=5 with the butterfly and RAMs: load impulse x[0]=0x4000_0000, others 0; start -> done after 80 cycles; every readout rd_adr 0..31 returns 0x4000_0000.
- End-to-end, M=5: load constant 0x0100_0000 in all 32 samples -> bin 0 = 0x2000_0000, all other bins = 0 (within ±1 LSB).
- Ignored inputs: start pulses mid-RUN -> no counter restart, done still at 80 cycles; load mid-RUN -> we0/we1 follow the level schedule only.
- Reset mid-RUN at cycle 37 -> next cycle IDLE, done=0, we0=we1=0. A following start completes 80 cycles later.
